// File: rtl/prv_trap_ctrl.sv
// rtl/prv_trap_ctrl.sv - trap sequencer: irq latching, exception/irq/mret arbitration, CSR update and PC redirect (optional PRV_TRAP_VECTORED_EN)
module prv_trap_ctrl #(
  parameter int                 NUM_IRQ   = 4,
  parameter int                 XLEN      = 32,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               global_ie,
  input  logic [NUM_IRQ-1:0] irq_clr,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_badaddr,
  input  logic               ret,
  input  logic [XLEN-1:0]    curr_pc,
  input  logic [XLEN-1:0]    xtvec,
  input  logic [XLEN-1:0]    xepc,
  input  logic               pipe_ready,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               csr_rup,
  output logic [31:0]        mcause_next,
  output logic [XLEN-1:0]    mepc_next,
  output logic [XLEN-1:0]    mbadaddr_next,
  output logic               mie_clr,
  output logic               mie_restore,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_REDIRECT, S_RET} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] irq_req;
  logic               irq_any;
  logic [3:0]         irq_idx;
  logic               take_exc, take_irq, take_ret;
  logic               ret_first;
  logic [XLEN-1:0]    trap_target;

  // Pending view: level channels follow the synced line, edge channels use the sticky bit
  always_comb begin
    irq_rise    = irq_in & ~irq_q;
    irq_pending = (irq_q & ~EDGE_MASK) | (edge_pend & EDGE_MASK);
    irq_req     = irq_pending & irq_en & {NUM_IRQ{global_ie}};
    irq_any     = |irq_req;
  end

  // Lowest-index requesting channel wins (scan downward so the last hit is the lowest)
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) irq_idx = 4'(i);
    end
  end

  // Event acceptance in IDLE: exception over interrupt over mret
  always_comb begin
    take_exc = (state == S_IDLE) && exc_valid;
    take_irq = (state == S_IDLE) && !exc_valid && irq_any;
    take_ret = (state == S_IDLE) && !exc_valid && !irq_any && ret;
  end

  // Redirect target; vectoring applies only to interrupts when xtvec[0] is set
  always_comb begin
    trap_target = {xtvec[XLEN-1:2], 2'b00};
`ifdef PRV_TRAP_VECTORED_EN
    if (xtvec[0] && mcause_next[31])
      trap_target = {xtvec[XLEN-1:2], 2'b00} + XLEN'({mcause_next[30:0], 2'b00});
`endif
  end

  // Input sync and edge-channel pending bits; a new rising edge beats a clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      irq_q     <= '0;
      edge_pend <= '0;
    end else begin
      irq_q     <= irq_in;
      edge_pend <= ((edge_pend & ~irq_clr) | irq_rise) & EDGE_MASK;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; exc_valid and ret are ignored outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_exc || take_irq) state_nxt = S_TRAP;
        else if (take_ret)        state_nxt = S_RET;
      end
      S_TRAP:               state_nxt = S_REDIRECT;
      S_REDIRECT, S_RET: if (pipe_ready) state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Trap record and redirect target; record holds until the next accepted trap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mcause_next   <= '0;
      mepc_next     <= '0;
      mbadaddr_next <= '0;
      priv_pc       <= '0;
      ret_first     <= 1'b0;
    end else begin
      ret_first <= take_ret;
      if (take_exc) begin
        mcause_next   <= {28'b0, exc_cause};
        mepc_next     <= exc_pc;
        mbadaddr_next <= exc_badaddr;
      end else if (take_irq) begin
        mcause_next   <= {1'b1, 26'b0, 1'b1, irq_idx};
        mepc_next     <= curr_pc;
        mbadaddr_next <= '0;
      end
      if (take_ret)
        priv_pc <= xepc;
      else if (state == S_TRAP)
        priv_pc <= trap_target;
    end
  end

  // Outputs decoded from state; mie_restore only in the first RET cycle
  always_comb begin
    csr_rup     = (state == S_TRAP);
    mie_clr     = (state == S_TRAP);
    insert_pc   = (state == S_REDIRECT) || (state == S_RET);
    busy        = (state != S_IDLE);
    mie_restore = (state == S_RET) && ret_first;
  end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// tb/tb_prv_trap_ctrl.sv - randomized and directed bench for prv_trap_ctrl with a behavioural model
module tb_prv_trap_ctrl;

  localparam int         N  = 4;
  localparam logic [3:0] EM = 4'b0001;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  irq_in = '0, irq_en = '0, irq_clr = '0;
  logic        global_ie = 1'b0, exc_valid = 1'b0, ret = 1'b0, pipe_ready = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0, exc_badaddr = '0, curr_pc = '0, xtvec = '0, xepc = '0;
  logic [3:0]  irq_pending;
  logic        csr_rup, mie_clr, mie_restore, insert_pc, busy;
  logic [31:0] mcause_next, mepc_next, mbadaddr_next, priv_pc;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: phase 0 = idle, 1 = CSR update cycle, 2 = waiting for redirect accept, 3 = mret redirect
  logic [3:0]  m_irq_q, m_edge;
  int          m_phase;
  logic        m_restore;
  logic [31:0] m_cause, m_epc, m_bad, m_pc;

  prv_trap_ctrl #(.NUM_IRQ(N), .XLEN(32), .EDGE_MASK(EM)) dut (
    .CLK(CLK), .nRST(nRST), .irq_in(irq_in), .irq_en(irq_en), .global_ie(global_ie),
    .irq_clr(irq_clr), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_badaddr(exc_badaddr), .ret(ret), .curr_pc(curr_pc), .xtvec(xtvec), .xepc(xepc),
    .pipe_ready(pipe_ready), .irq_pending(irq_pending), .csr_rup(csr_rup),
    .mcause_next(mcause_next), .mepc_next(mepc_next), .mbadaddr_next(mbadaddr_next),
    .mie_clr(mie_clr), .mie_restore(mie_restore), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] trap_dest(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
`ifdef PRV_TRAP_VECTORED_EN
    if (tv[0] && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
`endif
    return base;
  endfunction

  task automatic model_reset();
    m_irq_q = '0; m_edge = '0; m_phase = 0; m_restore = 1'b0;
    m_cause = '0; m_epc = '0; m_bad = '0; m_pc = '0;
  endtask

  // Advance the model by one clock using the inputs presently applied
  task automatic model_step();
    logic [3:0] pend, req;
    int win;
    logic nr;
    pend = (m_irq_q & ~EM) | (m_edge & EM);
    req  = pend & irq_en & {4{global_ie}};
    win  = -1;
    for (int i = 0; i < N; i++) if (req[i] && win < 0) win = i;
    nr = 1'b0;
    case (m_phase)
      0: begin
        if (exc_valid) begin
          m_cause = {28'b0, exc_cause}; m_epc = exc_pc; m_bad = exc_badaddr; m_phase = 1;
        end else if (win >= 0) begin
          m_cause = 32'h8000_0000 | 32'(16 + win); m_epc = curr_pc; m_bad = '0; m_phase = 1;
        end else if (ret) begin
          m_pc = xepc; m_phase = 3; nr = 1'b1;
        end
      end
      1: begin m_pc = trap_dest(xtvec, m_cause); m_phase = 2; end
      default: if (pipe_ready) m_phase = 0;
    endcase
    m_restore = nr;
    m_edge    = ((m_edge & ~irq_clr) | (irq_in & ~m_irq_q)) & EM;
    m_irq_q   = irq_in;
  endtask

  task automatic compare_all();
    check("irq_pending", 32'(irq_pending), 32'((m_irq_q & ~EM) | (m_edge & EM)));
    check("csr_rup",     32'(csr_rup),     32'(m_phase == 1));
    check("mie_clr",     32'(mie_clr),     32'(m_phase == 1));
    check("insert_pc",   32'(insert_pc),   32'(m_phase >= 2));
    check("busy",        32'(busy),        32'(m_phase != 0));
    check("mie_restore", 32'(mie_restore), 32'(m_restore));
    check("priv_pc",     priv_pc,          m_pc);
    check("mcause",      mcause_next,      m_cause);
    check("mepc",        mepc_next,        m_epc);
    check("mbadaddr",    mbadaddr_next,    m_bad);
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    xtvec = 32'h1000;
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    nRST = 1'b1;
    step();

    // exception with delayed redirect accept
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_badaddr = 32'hDEAD;
    step();
    check("exc_csr_rup", 32'(csr_rup), 32'd1);
    check("exc_mcause", mcause_next, 32'h2);
    exc_valid = 1'b0;
    step();
    check("exc_priv_pc", priv_pc, 32'h1000);
    step();
    step();
    check("exc_hold_insert", 32'(insert_pc), 32'd1);
    pipe_ready = 1'b1;
    step();
    check("exc_release", 32'(insert_pc), 32'd0);

    // exception beats pending interrupts; lowest channel taken next
    irq_in = 4'b1010; irq_en = 4'b1111; global_ie = 1'b1;
    step();
    exc_valid = 1'b1; exc_cause = 4'd5;
    step();
    check("prio_exc_first", mcause_next, 32'h5);
    exc_valid = 1'b0;
    step();
    step();
    step();
    check("prio_irq1", mcause_next, 32'h8000_0011);
    check("prio_ch3_pending", 32'(irq_pending[3]), 32'd1);
    global_ie = 1'b0; irq_in = '0;
    repeat (3) step();
    pipe_ready = 1'b0;

    // edge channel 0: sticky, set beats clear, clear alone clears
    irq_en = 4'b0000;
    irq_in = 4'b0001; step();
    irq_in = 4'b0000; step();
    check("edge_sticky", 32'(irq_pending[0]), 32'd1);
    irq_in = 4'b0001; irq_clr = 4'b0001; step();
    check("edge_set_wins", 32'(irq_pending[0]), 32'd1);
    irq_in = 4'b0000; irq_clr = 4'b0000; step();
    irq_clr = 4'b0001; step();
    check("edge_cleared", 32'(irq_pending[0]), 32'd0);
    irq_clr = 4'b0000;

    // mret; a held ret during RET is ignored
    xepc = 32'h2040; ret = 1'b1;
    step();
    check("ret_restore", 32'(mie_restore), 32'd1);
    check("ret_priv_pc", priv_pc, 32'h2040);
    step();
    check("ret_restore_once", 32'(mie_restore), 32'd0);
    ret = 1'b0; pipe_ready = 1'b1;
    step();
    check("ret_done", 32'(busy), 32'd0);
    pipe_ready = 1'b0;

    // vectored target for channel 2, then reset in REDIRECT
    xtvec = 32'h1001; irq_in = 4'b0100; irq_en = 4'b0100; global_ie = 1'b1;
    step();
    step();
    check("vec_mcause", mcause_next, 32'h8000_0012);
    global_ie = 1'b0; irq_in = '0;
    step();
`ifdef PRV_TRAP_VECTORED_EN
    check("vec_priv_pc", priv_pc, 32'h1048);
`else
    check("vec_priv_pc", priv_pc, 32'h1000);
`endif
    #2 nRST = 1'b0;
    #1;
    check("rst_insert_pc", 32'(insert_pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_csr_rup", 32'(csr_rup), 32'd0);
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
    step();
    check("rst_pending", 32'(irq_pending), 32'd0);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
      irq_en      = 4'($urandom);
      global_ie   = ($urandom_range(0, 3) != 0);
      irq_clr     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      exc_valid   = ($urandom_range(0, 5) == 0);
      exc_cause   = 4'($urandom);
      exc_pc      = $urandom;
      exc_badaddr = $urandom;
      ret         = ($urandom_range(0, 5) == 0);
      curr_pc     = $urandom;
      xtvec       = $urandom;
      xepc        = $urandom;
      pipe_ready  = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
